pipeline_stall_ctrl: RTL and testbench

Consumes the load-use `stall` from the hazard detection unit, together with branch-flush and data-memory-busy requests, and applies them to the front of the pipeline. Owns the IF/ID pipeline register and the ID/EX control-word register: it holds, flushes or bubbles them, gates the PC write, and keeps stall/flush performance counters plus a stall watchdog. Sits between the IF and ID stages, fed by the hazard unit, branch resolution in ID, and the data-memory interface.

---
 rtl/pipeline_pkg.sv | 44 ++++
 rtl/sat_counter.sv | 35 +++
 rtl/pipeline_stall_ctrl.sv | 162 ++++++++++++++++
 tb/tb_pipeline_stall_ctrl.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared definitions for the front-pipeline stall controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents: FSM/action encodings, NOP instruction, default control-word
// width, the IF/ID register layout and the priority action selector.
package pipeline_pkg;

  // Action / state encodings. The FSM state is simply the action taken on
  // the previous edge, so one encoding serves both.
  localparam logic [1:0] ST_RUN    = 2'd0;
  localparam logic [1:0] ST_BUBBLE = 2'd1;
  localparam logic [1:0] ST_FLUSH  = 2'd2;
  localparam logic [1:0] ST_FREEZE = 2'd3;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  localparam int DEF_CTRL_W    = 10;
  localparam int DEF_MAX_STALL = 8;

  // IF/ID pipeline register contents.
  typedef struct packed {
    logic [31:0] pc_plus4;
    logic [31:0] instr;
    logic        valid;
  } ifid_t;

  localparam ifid_t IFID_RESET = '{pc_plus4: 32'h0, instr: NOP_INSTR, valid: 1'b0};

  // Strict priority: memory freeze beats branch flush beats load-use bubble.
  // A flush wins over a bubble because the stalled instruction is being
  // squashed anyway; the hazard unit re-raises the stall if still needed.
  function automatic logic [1:0] select_action(input logic mem_busy,
                                               input logic branch_taken,
                                               input logic hazard_stall);
    logic [1:0] act;
    act = ST_RUN;
    if (mem_busy)          act = ST_FREEZE;
    else if (branch_taken) act = ST_FLUSH;
    else if (hazard_stall) act = ST_BUBBLE;
    return act;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
// Latency: count reflects inc/clr one edge later.
// Backpressure: none; once all-ones, further increments are ignored.
//
// Ports: clk, rst_n (sync, active-low), clr (sync clear, wins over inc),
//        inc (increment enable), count (current value).
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] cnt_q;
  logic         at_max;

  assign at_max = &cnt_q;
  assign count  = cnt_q;

  // The register is only written when it actually changes; holding is
  // implicit so the value is never disturbed by idle cycles.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (inc && !at_max) begin
      cnt_q <= cnt_q + W'(1);
    end
  end

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Front-pipeline stall/flush controller owning the IF/ID and ID/EX control registers.
// Latency: pc_write combinational; IF/ID, ID/EX, state and counters update one edge later.
// Backpressure: mem_busy freezes everything (requests not latched, upstream must hold);
//               hazard_stall holds IF/ID and the PC while inserting an ID/EX bubble.
//
// Ports:
//   clk, rst_n                          clock, synchronous active-low reset
//   hazard_stall, branch_taken, mem_busy requests (priority mem_busy > branch > hazard)
//   if_pc_plus4, if_instr               fetched instruction and its PC+4
//   id_ctrl                             decoded control word of the ID instruction
//   pc_write                            PC register enable
//   ifid_pc_plus4, ifid_instr, ifid_valid  IF/ID register
//   idex_ctrl, idex_valid               ID/EX control register
//   state                               action taken on the previous edge
//   stall_count, flush_count            saturating BUBBLE / FLUSH cycle counters
//   stall_timeout                       sticky: MAX_STALL consecutive non-RUN cycles seen
module pipeline_stall_ctrl
  import pipeline_pkg::*;
#(
  parameter int CTRL_W    = DEF_CTRL_W,
  parameter int MAX_STALL = DEF_MAX_STALL
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              hazard_stall,
  input  logic              branch_taken,
  input  logic              mem_busy,
  input  logic [31:0]       if_pc_plus4,
  input  logic [31:0]       if_instr,
  input  logic [CTRL_W-1:0] id_ctrl,
  output logic              pc_write,
  output logic [31:0]       ifid_pc_plus4,
  output logic [31:0]       ifid_instr,
  output logic              ifid_valid,
  output logic [CTRL_W-1:0] idex_ctrl,
  output logic              idex_valid,
  output logic [1:0]        state,
  output logic [31:0]       stall_count,
  output logic [31:0]       flush_count,
  output logic              stall_timeout
);

  logic [1:0]        act;
  logic [1:0]        state_q;
  ifid_t             ifid_q;
  ifid_t             ifid_d;
  logic [CTRL_W-1:0] idex_ctrl_q;
  logic [CTRL_W-1:0] idex_ctrl_d;
  logic              idex_valid_q;
  logic              idex_valid_d;
  logic [7:0]        run_len;
  logic              non_run;
  logic              wd_hit;
  logic              timeout_q;

  // ------------------------------------------------------------------
  // Action selection and PC enable
  // ------------------------------------------------------------------
  assign act     = select_action(mem_busy, branch_taken, hazard_stall);
  assign non_run = (act != ST_RUN);

  // The PC advances on RUN and on FLUSH (the branch target is loaded);
  // it is held during a bubble or freeze and forced low in reset.
  assign pc_write = rst_n && ((act == ST_RUN) || (act == ST_FLUSH));

  // ------------------------------------------------------------------
  // Next-value logic for the pipeline registers
  // ------------------------------------------------------------------
  always_comb begin
    ifid_d       = ifid_q;
    idex_ctrl_d  = idex_ctrl_q;
    idex_valid_d = idex_valid_q;
    case (act)
      ST_RUN: begin
        ifid_d       = '{pc_plus4: if_pc_plus4, instr: if_instr, valid: 1'b1};
        idex_ctrl_d  = id_ctrl;
        idex_valid_d = 1'b1;
      end
      ST_FLUSH: begin
        // The wrong-path fetch is squashed; the branch itself still moves on.
        ifid_d       = IFID_RESET;
        idex_ctrl_d  = id_ctrl;
        idex_valid_d = 1'b1;
      end
      ST_BUBBLE: begin
        // IF/ID holds the dependent instruction; EX receives a NOP.
        idex_ctrl_d  = '0;
        idex_valid_d = 1'b0;
      end
      default: begin
        // FREEZE: everything holds.
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_RUN;
      ifid_q       <= IFID_RESET;
      idex_ctrl_q  <= '0;
      idex_valid_q <= 1'b0;
    end else begin
      state_q      <= act;
      ifid_q       <= ifid_d;
      idex_ctrl_q  <= idex_ctrl_d;
      idex_valid_q <= idex_valid_d;
    end
  end

  // ------------------------------------------------------------------
  // Performance counters and watchdog run length
  // ------------------------------------------------------------------
  sat_counter #(.W(32)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (1'b0),
    .inc   (act == ST_BUBBLE),
    .count (stall_count)
  );

  sat_counter #(.W(32)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (1'b0),
    .inc   (act == ST_FLUSH),
    .count (flush_count)
  );

  // Consecutive non-RUN edges; any RUN edge restarts the count.
  sat_counter #(.W(8)) u_run_len (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (!non_run),
    .inc   (non_run),
    .count (run_len)
  );

  // The flag sets on the same edge the run length reaches MAX_STALL, so it is
  // computed from the pre-increment value. The 9-bit sum keeps a saturated
  // run length of 255 from wrapping.
  assign wd_hit = non_run && (({1'b0, run_len} + 9'd1) >= 9'(MAX_STALL));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      timeout_q <= 1'b0;
    end else if (wd_hit) begin
      timeout_q <= 1'b1;
    end
  end

  // ------------------------------------------------------------------
  // Outputs
  // ------------------------------------------------------------------
  assign ifid_pc_plus4 = ifid_q.pc_plus4;
  assign ifid_instr    = ifid_q.instr;
  assign ifid_valid    = ifid_q.valid;
  assign idex_ctrl     = idex_ctrl_q;
  assign idex_valid    = idex_valid_q;
  assign state         = state_q;
  assign stall_timeout = timeout_q;

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Directed testbench for pipeline_stall_ctrl.
// Latency: n/a.
// Backpressure: n/a.
module tb_pipeline_stall_ctrl;

  localparam int CTRL_W    = 10;
  localparam int MAX_STALL = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              hazard_stall;
  logic              branch_taken;
  logic              mem_busy;
  logic [31:0]       if_pc_plus4;
  logic [31:0]       if_instr;
  logic [CTRL_W-1:0] id_ctrl;
  logic              pc_write;
  logic [31:0]       ifid_pc_plus4;
  logic [31:0]       ifid_instr;
  logic              ifid_valid;
  logic [CTRL_W-1:0] idex_ctrl;
  logic              idex_valid;
  logic [1:0]        state;
  logic [31:0]       stall_count;
  logic [31:0]       flush_count;
  logic              stall_timeout;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipeline_stall_ctrl #(.CTRL_W(CTRL_W), .MAX_STALL(MAX_STALL)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .hazard_stall  (hazard_stall),
    .branch_taken  (branch_taken),
    .mem_busy      (mem_busy),
    .if_pc_plus4   (if_pc_plus4),
    .if_instr      (if_instr),
    .id_ctrl       (id_ctrl),
    .pc_write      (pc_write),
    .ifid_pc_plus4 (ifid_pc_plus4),
    .ifid_instr    (ifid_instr),
    .ifid_valid    (ifid_valid),
    .idex_ctrl     (idex_ctrl),
    .idex_valid    (idex_valid),
    .state         (state),
    .stall_count   (stall_count),
    .flush_count   (flush_count),
    .stall_timeout (stall_timeout)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
    end
  endtask

  // Advance one edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic mb, input logic bt, input logic hs);
    mem_busy     = mb;
    branch_taken = bt;
    hazard_stall = hs;
  endtask

  task automatic check_reset_state(input string tag);
    check_eq({tag, "_ifid_pc"},    ifid_pc_plus4, 32'h0);
    check_eq({tag, "_ifid_instr"}, ifid_instr,    32'h0);
    check_eq({tag, "_ifid_valid"}, 32'(ifid_valid), 32'h0);
    check_eq({tag, "_idex_ctrl"},  32'(idex_ctrl),  32'h0);
    check_eq({tag, "_idex_valid"}, 32'(idex_valid), 32'h0);
    check_eq({tag, "_state"},      32'(state),      32'h0);
    check_eq({tag, "_stall_cnt"},  stall_count,   32'h0);
    check_eq({tag, "_flush_cnt"},  flush_count,   32'h0);
    check_eq({tag, "_timeout"},    32'(stall_timeout), 32'h0);
    check_eq({tag, "_pc_write"},   32'(pc_write),   32'h0);
  endtask

  initial begin
    rst_n       = 1'b0;
    set_req(1'b0, 1'b0, 1'b0);
    if_pc_plus4 = 32'h0;
    if_instr    = 32'h0;
    id_ctrl     = '0;

    // Reset
    tick();
    tick();
    check_reset_state("rst");

    // RUN
    rst_n       = 1'b1;
    if_instr    = 32'h8C08_0004;
    if_pc_plus4 = 32'h0000_0008;
    id_ctrl     = 10'h155;
    #1 check_eq("run_pcw_pre", 32'(pc_write), 32'h1);
    tick();
    check_eq("run_ifid_instr", ifid_instr,    32'h8C08_0004);
    check_eq("run_ifid_pc",    ifid_pc_plus4, 32'h0000_0008);
    check_eq("run_ifid_valid", 32'(ifid_valid), 32'h1);
    check_eq("run_idex_ctrl",  32'(idex_ctrl),  32'h155);
    check_eq("run_idex_valid", 32'(idex_valid), 32'h1);
    check_eq("run_state",      32'(state),      32'h0);
    check_eq("run_pcw_post",   32'(pc_write),   32'h1);

    // One-cycle BUBBLE
    set_req(1'b0, 1'b0, 1'b1);
    if_instr = 32'h1111_1111;
    id_ctrl  = 10'h2AA;
    #1 check_eq("bub_pcw", 32'(pc_write), 32'h0);
    tick();
    check_eq("bub_ifid_instr", ifid_instr,    32'h8C08_0004);
    check_eq("bub_ifid_valid", 32'(ifid_valid), 32'h1);
    check_eq("bub_idex_ctrl",  32'(idex_ctrl),  32'h0);
    check_eq("bub_idex_valid", 32'(idex_valid), 32'h0);
    check_eq("bub_state",      32'(state),      32'h1);
    check_eq("bub_stall_cnt",  stall_count,   32'h1);

    // branch_taken with hazard_stall -> FLUSH
    set_req(1'b0, 1'b1, 1'b1);
    id_ctrl = 10'h0F0;
    #1 check_eq("fl_pcw", 32'(pc_write), 32'h1);
    tick();
    check_eq("fl_ifid_instr", ifid_instr,    32'h0);
    check_eq("fl_ifid_pc",    ifid_pc_plus4, 32'h0);
    check_eq("fl_ifid_valid", 32'(ifid_valid), 32'h0);
    check_eq("fl_idex_ctrl",  32'(idex_ctrl),  32'h0F0);
    check_eq("fl_idex_valid", 32'(idex_valid), 32'h1);
    check_eq("fl_state",      32'(state),      32'h2);
    check_eq("fl_flush_cnt",  flush_count,   32'h1);
    check_eq("fl_stall_cnt",  stall_count,   32'h1);

    // RUN to load known values before freezing
    set_req(1'b0, 1'b0, 1'b0);
    if_instr    = 32'h2222_2222;
    if_pc_plus4 = 32'h0000_000C;
    id_ctrl     = 10'h3C3;
    tick();
    check_eq("run2_ifid_instr", ifid_instr, 32'h2222_2222);
    check_eq("run2_state",      32'(state),   32'h0);

    // FREEZE for 3 cycles with branch_taken also asserted
    set_req(1'b1, 1'b1, 1'b0);
    if_instr = 32'h3333_3333;
    id_ctrl  = 10'h001;
    for (int i = 0; i < 3; i++) begin
      #1 check_eq("frz_pcw", 32'(pc_write), 32'h0);
      tick();
      check_eq("frz_ifid_instr", ifid_instr,    32'h2222_2222);
      check_eq("frz_ifid_pc",    ifid_pc_plus4, 32'h0000_000C);
      check_eq("frz_idex_ctrl",  32'(idex_ctrl),  32'h3C3);
      check_eq("frz_idex_valid", 32'(idex_valid), 32'h1);
      check_eq("frz_state",      32'(state),      32'h3);
      check_eq("frz_stall_cnt",  stall_count,   32'h1);
      check_eq("frz_flush_cnt",  flush_count,   32'h1);
    end

    // RUN edge restarts the watchdog run length
    set_req(1'b0, 1'b0, 1'b0);
    tick();
    check_eq("wd_pre", 32'(stall_timeout), 32'h0);

    // 8 consecutive BUBBLE edges: timeout on the 8th
    set_req(1'b0, 1'b0, 1'b1);
    for (int i = 1; i <= 8; i++) begin
      tick();
      check_eq("wd_timeout", 32'(stall_timeout), (i >= MAX_STALL) ? 32'h1 : 32'h0);
    end
    check_eq("wd_stall_cnt", stall_count, 32'd9);

    // Sticky through RUN
    set_req(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("wd_sticky", 32'(stall_timeout), 32'h1);
    end

    // Saturation of stall_count
    force dut.u_stall_cnt.cnt_q = 32'hFFFF_FFFE;
    #1;
    release dut.u_stall_cnt.cnt_q;
    #1;
    check_eq("sat_preload", stall_count, 32'hFFFF_FFFE);
    set_req(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("sat_stall_cnt", stall_count, 32'hFFFF_FFFF);
      check_eq("sat_flush_cnt", flush_count, 32'h1);
    end

    // Reset mid-FREEZE
    set_req(1'b1, 1'b0, 1'b0);
    tick();
    check_eq("pre_rst_state", 32'(state), 32'h3);
    rst_n = 1'b0;
    tick();
    check_reset_state("midrst");

    rst_n = 1'b1;
    set_req(1'b0, 1'b0, 1'b0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global time limit so the bench can never hang.
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
